// File: rtl/calc_seq_ctrl.sv
// Operation sequencer for the 8-bit calculator: latches operands and operator,
// runs the ALU handshake with a timeout, and owns the display/error/clear policy.
module calc_seq_ctrl #(
   parameter int ALU_TIMEOUT = 16
) (
   input  logic       i_sys_clock,
   input  logic       i_sys_reset,
   input  logic       i_clear,
   input  logic [3:0] i_op_key,
   input  logic       i_equal,
   input  logic [7:0] i_kp_keycode,
   input  logic       i_kp_overflow,
   input  logic       i_kp_new_input,
   input  logic       i_alu_done,
   input  logic       i_alu_error,
   input  logic [7:0] i_alu_result,
   output logic       o_kp_clear,
   output logic       o_kp_op_valid,
   output logic       o_alu_start,
   output logic [7:0] o_alu_a,
   output logic [7:0] o_alu_b,
   output logic [1:0] o_alu_op,
   output logic [7:0] o_disp_value,
   output logic [2:0] o_state,
   output logic       o_error,
   output logic       o_busy
);

   localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      OP_SEL  = 3'd1,
      ENTER_B = 3'd2,
      EXEC    = 3'd3,
      RESULT  = 3'd4,
      ERROR   = 3'd5
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       op_prev;
   logic             equal_prev;
   logic [3:0]       op_rise;
   logic             op_evt, eq_evt;
   logic [1:0]       op_enc;
   logic [7:0]       a, a_nxt, b, b_nxt, result, result_nxt, disp, disp_nxt;
   logic [1:0]       op, op_nxt, pend, pend_nxt;
   logic             chain, chain_nxt;
   logic             start, start_nxt, opv, opv_nxt;
   logic             kp_clear, err, busy;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

   function automatic logic [1:0] encode_op(input logic [3:0] key);
      case (key)
         4'b0010: encode_op = 2'd1;
         4'b0100: encode_op = 2'd2;
         4'b1000: encode_op = 2'd3;
         default: encode_op = 2'd0;
      endcase
   endfunction

   // A multi-bit rise is not an operator event; an operator event masks equal.
   assign op_rise = i_op_key & ~op_prev;
   assign op_evt  = $onehot(op_rise);
   assign op_enc  = encode_op(op_rise);
   assign eq_evt  = i_equal & ~equal_prev & ~op_evt;
   assign cnt_inc = cnt + 1'b1;

   always_comb begin
      state_nxt  = state;
      a_nxt      = a;
      b_nxt      = b;
      op_nxt     = op;
      pend_nxt   = pend;
      chain_nxt  = chain;
      result_nxt = result;
      cnt_nxt    = cnt;
      start_nxt  = 1'b0;
      opv_nxt    = 1'b0;
      disp_nxt   = disp;

      if (i_clear) begin
         state_nxt  = ENTER_A;
         a_nxt      = '0;
         b_nxt      = '0;
         op_nxt     = '0;
         pend_nxt   = '0;
         chain_nxt  = 1'b0;
         result_nxt = '0;
         cnt_nxt    = '0;
      end else begin
         case (state)
            ENTER_A: begin
               if (i_kp_overflow) begin
                  state_nxt = ERROR;
               end else if (op_evt) begin
                  a_nxt     = i_kp_keycode;
                  op_nxt    = op_enc;
                  opv_nxt   = 1'b1;
                  state_nxt = OP_SEL;
               end
            end
            OP_SEL: begin
               if (op_evt) op_nxt = op_enc;
               if (i_kp_new_input) state_nxt = ENTER_B;
            end
            ENTER_B: begin
               if (i_kp_overflow) begin
                  state_nxt = ERROR;
               end else if (op_evt || eq_evt) begin
                  b_nxt     = i_kp_keycode;
                  start_nxt = 1'b1;
                  cnt_nxt   = '0;
                  chain_nxt = op_evt;
                  if (op_evt) pend_nxt = op_enc;
                  state_nxt = EXEC;
               end
            end
            EXEC: begin
               // The count is checked after increment, so a done in the same cycle still wins.
               cnt_nxt = cnt_inc;
               if (i_alu_done) begin
                  if (i_alu_error) begin
                     state_nxt = ERROR;
                  end else begin
                     result_nxt = i_alu_result;
                     if (chain) begin
                        a_nxt     = i_alu_result;
                        op_nxt    = pend;
                        opv_nxt   = 1'b1;
                        chain_nxt = 1'b0;
                        state_nxt = OP_SEL;
                     end else begin
                        state_nxt = RESULT;
                     end
                  end
               end else if (cnt_inc == CNT_W'(ALU_TIMEOUT)) begin
                  state_nxt = ERROR;
               end
            end
            RESULT: begin
               if (op_evt) begin
                  a_nxt     = result;
                  op_nxt    = op_enc;
                  opv_nxt   = 1'b1;
                  state_nxt = OP_SEL;
               end else if (i_kp_new_input) begin
                  state_nxt = ENTER_A;
               end
            end
            ERROR:   state_nxt = ERROR;
            default: state_nxt = ENTER_A;
         endcase
      end

      // Display follows the state being entered so it is correct on arrival.
      case (state_nxt)
         ENTER_A, ENTER_B: disp_nxt = i_kp_keycode;
         OP_SEL:           disp_nxt = a_nxt;
         EXEC:             disp_nxt = disp;
         RESULT:           disp_nxt = result_nxt;
         default:          disp_nxt = '0;
      endcase
      if (i_clear) disp_nxt = '0;
   end

   always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
      if (i_sys_reset) begin
         state      <= ENTER_A;
         op_prev    <= '0;
         equal_prev <= 1'b0;
         a          <= '0;
         b          <= '0;
         op         <= '0;
         pend       <= '0;
         chain      <= 1'b0;
         result     <= '0;
         cnt        <= '0;
         start      <= 1'b0;
         opv        <= 1'b0;
         disp       <= '0;
         kp_clear   <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         op_prev    <= i_op_key;
         equal_prev <= i_equal;
         a          <= a_nxt;
         b          <= b_nxt;
         op         <= op_nxt;
         pend       <= pend_nxt;
         chain      <= chain_nxt;
         result     <= result_nxt;
         cnt        <= cnt_nxt;
         start      <= start_nxt;
         opv        <= opv_nxt;
         disp       <= disp_nxt;
         kp_clear   <= i_clear;
         err        <= (state_nxt == ERROR);
         busy       <= (state_nxt == EXEC);
      end
   end

   assign o_kp_clear    = kp_clear;
   assign o_kp_op_valid = opv;
   assign o_alu_start   = start;
   assign o_alu_a       = a;
   assign o_alu_b       = b;
   assign o_alu_op      = op;
   assign o_disp_value  = disp;
   assign o_state       = state;
   assign o_error       = err;
   assign o_busy        = busy;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: operand entry, chaining, errors, timeout
// boundary, simultaneous events and asynchronous reset.
module tb_calc_seq_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       clear, equal, kp_overflow, kp_new_input;
   logic       alu_done, alu_error;
   logic [3:0] op_key;
   logic [7:0] kp_keycode, alu_result;
   logic       kp_clear, kp_op_valid, alu_start, error, busy;
   logic [7:0] alu_a, alu_b, disp_value;
   logic [1:0] alu_op;
   logic [2:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   calc_seq_ctrl #(.ALU_TIMEOUT(16)) dut (
      .i_sys_clock    (clock),
      .i_sys_reset    (reset),
      .i_clear        (clear),
      .i_op_key       (op_key),
      .i_equal        (equal),
      .i_kp_keycode   (kp_keycode),
      .i_kp_overflow  (kp_overflow),
      .i_kp_new_input (kp_new_input),
      .i_alu_done     (alu_done),
      .i_alu_error    (alu_error),
      .i_alu_result   (alu_result),
      .o_kp_clear     (kp_clear),
      .o_kp_op_valid  (kp_op_valid),
      .o_alu_start    (alu_start),
      .o_alu_a        (alu_a),
      .o_alu_b        (alu_b),
      .o_alu_op       (alu_op),
      .o_disp_value   (disp_value),
      .o_state        (state),
      .o_error        (error),
      .o_busy         (busy)
   );

   always #5 clock = ~clock;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Enter operand A with the given operator, then move to ENTER_B.
   task automatic enter_a_op(input logic [7:0] key, input logic [3:0] opk);
      kp_keycode = key;
      op_key = opk;
      tick();
      op_key = 4'b0;
      kp_new_input = 1'b1;
      tick();
      kp_new_input = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; clear = 1'b0; equal = 1'b0; kp_overflow = 1'b0;
      kp_new_input = 1'b0; alu_done = 1'b0; alu_error = 1'b0;
      op_key = 4'b0; kp_keycode = 8'h00; alu_result = 8'h00;
      tick(); tick();
      reset = 1'b0;
      tick();

      // Reset state
      chk_eq("rst_state", state, 0);
      chk_eq("rst_outs", {kp_clear, kp_op_valid, alu_start, error, busy}, 0);
      chk_eq("rst_alu", {alu_a, alu_b, alu_op}, 0);
      chk_eq("rst_disp", disp_value, 0);

      // o_kp_clear is i_clear delayed one cycle
      clear = 1'b1;
      #1 chk_eq("kpclr_pre", kp_clear, 0);
      tick();
      chk_eq("kpclr_hi", kp_clear, 1);
      clear = 1'b0;
      tick();
      chk_eq("kpclr_lo", kp_clear, 0);

      // Add: 0x12 + 0x34
      kp_keycode = 8'h12;
      tick();
      chk_eq("add_dispA", disp_value, 8'h12);
      op_key = 4'b0001;
      tick();
      chk_eq("add_opsel", state, 1);
      chk_eq("add_opv", kp_op_valid, 1);
      chk_eq("add_a", alu_a, 8'h12);
      tick();
      chk_eq("add_opv_once", kp_op_valid, 0);
      op_key = 4'b0;
      kp_new_input = 1'b1;
      tick();
      chk_eq("add_enterb", state, 2);
      kp_new_input = 1'b0;
      kp_keycode = 8'h34;
      tick();
      chk_eq("add_dispB", disp_value, 8'h34);
      equal = 1'b1;
      tick();
      chk_eq("add_exec", state, 3);
      chk_eq("add_start", alu_start, 1);
      chk_eq("add_busy", busy, 1);
      chk_eq("add_abop", {alu_a, alu_b, 6'b0, alu_op}, {8'h12, 8'h34, 8'h00});
      equal = 1'b0;
      tick();
      chk_eq("add_start_once", alu_start, 0);
      alu_done = 1'b1; alu_result = 8'h46;
      tick();
      alu_done = 1'b0;
      chk_eq("add_result", state, 4);
      chk_eq("add_disp", disp_value, 8'h46);
      chk_eq("add_notbusy", busy, 0);

      // Chain: 0x05 - 0x02 then mul
      kp_keycode = 8'h05; kp_new_input = 1'b1;
      tick();
      kp_new_input = 1'b0;
      chk_eq("chn_entera", state, 0);
      chk_eq("chn_disp", disp_value, 8'h05);
      enter_a_op(8'h05, 4'b0010);
      chk_eq("chn_enterb", state, 2);
      kp_keycode = 8'h02;
      tick();
      op_key = 4'b0100;
      tick();
      chk_eq("chn_exec", state, 3);
      chk_eq("chn_abop", {alu_a, alu_b, 6'b0, alu_op}, {8'h05, 8'h02, 8'h01});
      tick();
      op_key = 4'b0;
      alu_done = 1'b1; alu_result = 8'h03;
      tick();
      alu_done = 1'b0;
      chk_eq("chn_opsel", state, 1);
      chk_eq("chn_a", alu_a, 8'h03);
      chk_eq("chn_op", alu_op, 2);
      chk_eq("chn_opv", kp_op_valid, 1);
      chk_eq("chn_disp", disp_value, 8'h03);
      tick();
      chk_eq("chn_opv_once", kp_op_valid, 0);

      // Divide by zero
      do_clear();
      chk_eq("clr_state", state, 0);
      chk_eq("clr_a", alu_a, 0);
      enter_a_op(8'h09, 4'b1000);
      kp_keycode = 8'h00; equal = 1'b1;
      tick();
      equal = 1'b0;
      chk_eq("dz_exec", {alu_b, 6'b0, alu_op}, {8'h00, 8'h03});
      alu_done = 1'b1; alu_error = 1'b1;
      tick();
      alu_done = 1'b0; alu_error = 1'b0;
      chk_eq("dz_state", state, 5);
      chk_eq("dz_error", error, 1);
      chk_eq("dz_disp", disp_value, 0);
      op_key = 4'b0001; equal = 1'b1; kp_new_input = 1'b1; kp_keycode = 8'h77;
      tick();
      chk_eq("dz_ignore", state, 5);
      op_key = 4'b0; equal = 1'b0; kp_new_input = 1'b0;
      tick();
      chk_eq("dz_stay", {state, error}, {3'd5, 1'b1});
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_eq("dz_clear", {state, error}, {3'd0, 1'b0});

      // Timeout: no done, ERROR 16 cycles after start
      enter_a_op(8'h07, 4'b0001);
      equal = 1'b1;
      tick();
      equal = 1'b0;
      chk_eq("to_start", alu_start, 1);
      for (int i = 0; i < 15; i++) tick();
      chk_eq("to_still_exec", state, 3);
      tick();
      chk_eq("to_error", state, 5);
      chk_eq("to_errflag", error, 1);
      do_clear();

      // Done on the timeout cycle wins
      enter_a_op(8'h08, 4'b0001);
      equal = 1'b1;
      tick();
      equal = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      alu_done = 1'b1; alu_result = 8'h55;
      tick();
      alu_done = 1'b0;
      chk_eq("to_done_wins", state, 4);
      chk_eq("to_done_disp", disp_value, 8'h55);
      do_clear();

      // Clear and add together: clear wins
      kp_keycode = 8'h11; clear = 1'b1; op_key = 4'b0001;
      tick();
      clear = 1'b0;
      chk_eq("clradd_state", state, 0);
      chk_eq("clradd_opv", kp_op_valid, 0);
      tick();
      chk_eq("clradd_held", state, 0);
      op_key = 4'b0;
      tick();

      // Add and sub together: ignored
      op_key = 4'b0011;
      tick();
      chk_eq("multi_state", state, 0);
      chk_eq("multi_opv", kp_op_valid, 0);
      op_key = 4'b0;
      tick();

      // Operator and equal together in ENTER_B: operator wins (chains)
      enter_a_op(8'h04, 4'b0001);
      kp_keycode = 8'h03; op_key = 4'b0010; equal = 1'b1;
      tick();
      op_key = 4'b0; equal = 1'b0;
      chk_eq("opeq_exec", state, 3);
      alu_done = 1'b1; alu_result = 8'h07;
      tick();
      alu_done = 1'b0;
      chk_eq("opeq_chain", {state, 3'b0, alu_op, alu_a}, {3'd1, 5'h01, 8'h07});
      do_clear();

      // Keypad overflow in ENTER_A
      kp_overflow = 1'b1;
      tick();
      kp_overflow = 1'b0;
      chk_eq("ovf_state", state, 5);
      do_clear();

      // Async reset mid-EXEC, later done ignored
      enter_a_op(8'h02, 4'b0001);
      equal = 1'b1;
      tick();
      equal = 1'b0;
      chk_eq("ar_exec", state, 3);
      #2 reset = 1'b1;
      #1;
      chk_eq("ar_async", {state, busy, alu_a}, 0);
      tick();
      reset = 1'b0; kp_keycode = 8'h00;
      alu_done = 1'b1; alu_result = 8'h99;
      tick();
      alu_done = 1'b0;
      chk_eq("ar_state", state, 0);
      chk_eq("ar_outs", {kp_op_valid, alu_start, error, busy, disp_value}, 0);
      chk_eq("ar_alu", {alu_a, alu_b, alu_op}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
